// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pkg
//  Purpose  : Shared constants for the seven-segment scan driver: converter
//             state encoding, active-low segment patterns {g,f,e,d,c,b,a},
//             largest displayable value and a nibble-to-segment decoder.
//  Revision : 1.0  initial release
// ============================================================================
package sseg_pkg;

  // Converter states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int MAX_DISPLAY = 9999;

  // BCD nibble to segment pattern; non-decimal codes show nothing
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_driver_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential shift-add-3 (double-dabble) binary to 4-digit BCD
//             converter. One strobe captures DIN; N shift cycles later the
//             result is presented for one LATCH cycle (done high) together
//             with an overflow flag for captured values above 9999.
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int N = 14
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [N-1:0] DIN,
  input  logic         VALID,
  output logic         BUSY,
  output logic [15:0]  bcd,
  output logic         ovf,
  output logic         done
);

  localparam int c_CW = $clog2(N + 1);

  logic [1:0]      r_state;
  logic [N-1:0]    r_shift;
  logic [15:0]     r_scratch;
  logic [c_CW-1:0] r_bits;
  logic            r_ovf;

  logic [15:0]     w_adj;
  logic            w_din_ovf;

  // Range check on the raw input so LATCH can substitute the dash display
  assign w_din_ovf = ({{(32 - N){1'b0}}, DIN} > 32'(MAX_DISPLAY));

  // Add-3 correction on every scratch nibble that would exceed 9 after doubling
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_adj[gi*4 +: 4] = (r_scratch[gi*4 +: 4] >= 4'd5)
                            ? r_scratch[gi*4 +: 4] + 4'd3
                            : r_scratch[gi*4 +: 4];
  end

  // Conversion FSM: capture, N correct-and-shift steps, then one latch cycle
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_bits    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (VALID) begin
            r_shift   <= DIN;
            r_scratch <= '0;
            r_bits    <= c_CW'(N);
            r_ovf     <= w_din_ovf;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= {w_adj[14:0], r_shift[N-1]};
          r_shift   <= {r_shift[N-2:0], 1'b0};
          r_bits    <= r_bits - c_CW'(1);
          if (r_bits == c_CW'(1)) begin
            r_state <= LATCH;
          end
        end
        LATCH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY = (r_state != IDLE);
  assign done = (r_state == LATCH);
  assign bcd  = r_scratch;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_driver
//  Purpose  : Converts an N-bit count to BCD and drives a time-multiplexed
//             common-anode 4-digit seven-segment display. The last converted
//             value stays on the display while the next conversion runs.
//  Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits (digit 0 is
//             always shown; overflow dashes are unaffected).
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N           = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic [N-1:0] DIN,
  input  logic         VALID,
  output logic         BUSY,
  output logic [6:0]   SEG,
  output logic [3:0]   AN,
  output logic         DP
);

  localparam int c_RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [c_RW-1:0] r_refresh;
  logic [1:0]      r_idx;
  logic [15:0]     r_disp;
  logic            r_disp_ovf;
  logic [6:0]      r_seg;
  logic [3:0]      r_an;

  logic [15:0]     w_bcd;
  logic            w_ovf;
  logic            w_done;
  logic [3:0]      w_nib;
  logic            w_blank;
  logic [6:0]      w_seg_next;

  bin2bcd_seq #(
    .N(N)
  ) u_bin2bcd (
    .clk  (clk),
    .RESET(RESET),
    .DIN  (DIN),
    .VALID(VALID),
    .BUSY (BUSY),
    .bcd  (w_bcd),
    .ovf  (w_ovf),
    .done (w_done)
  );

  // Display register: takes the new result only when a conversion finishes
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
    end else if (w_done) begin
      r_disp     <= w_bcd;
      r_disp_ovf <= w_ovf;
    end
  end

  // Refresh divider and digit index, free-running regardless of conversions
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
    end else if (r_refresh == c_RW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_refresh <= r_refresh + c_RW'(1);
    end
  end

  // Select the active digit and decide what pattern it should show
  always_comb begin
    w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every more significant digit are 0
    case (r_idx)
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
      2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
`endif
    if (r_disp_ovf) begin
      w_seg_next = SEG_DASH;
    end else if (w_blank) begin
      w_seg_next = SEG_BLANK;
    end else begin
      w_seg_next = seg_decode(w_nib);
    end
  end

  // Registered pin drivers so the display sees no combinational glitches
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_seg <= SEG_DIGIT[0];
      r_an  <= 4'b1110;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= ~(4'b0001 << r_idx);
    end
  end

  assign SEG = r_seg;
  assign AN  = r_an;
  assign DP  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_driver
//  Purpose  : Self-checking bench for sseg_scan_driver. Directed scenarios
//             followed by random strobes/values/resets, compared every cycle
//             against a behavioural model built from cycle arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_driver;

  localparam int N   = 14;
  localparam int DIV = 4;

  logic         clk   = 1'b0;
  logic         RESET = 1'b1;
  logic         VALID = 1'b0;
  logic [N-1:0] DIN   = '0;
  logic         BUSY;
  logic [6:0]   SEG;
  logic [3:0]   AN;
  logic         DP;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: edges since reset, edge of last accepted strobe,
  // pending result and what the display currently holds
  int e         = 0;
  int acc       = -1000;
  int pend_edge = -1;
  int pend_val  = 0;
  bit pend_ovf  = 1'b0;
  int disp_val  = 0;
  bit disp_ovf  = 1'b0;
  int exp_busy, exp_an, exp_seg;

  int seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                       7'b0000000, 7'b0010000};

  sseg_scan_driver #(
    .N          (N),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .DIN  (DIN),
    .VALID(VALID),
    .BUSY (BUSY),
    .SEG  (SEG),
    .AN   (AN),
    .DP   (DP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // Pattern expected for digit slot idx given the displayed value
  function automatic int seg_of(input int val, input bit ovf, input int idx);
    bit blank;
    if (ovf) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 0) && (val < pow10(idx));
`else
    blank = 1'b0;
`endif
    if (blank) return 7'b1111111;
    return seg_tab[(val / pow10(idx)) % 10];
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare
  task automatic step(input bit r, input bit v, input int d);
    int pv, pidx;
    bit po;
    RESET = r;
    VALID = v;
    DIN   = N'(d);
    @(posedge clk);
    cyc++;
    if (r) begin
      e = 0; acc = -1000; pend_edge = -1;
      disp_val = 0; disp_ovf = 1'b0;
      exp_busy = 0; exp_an = 4'b1110; exp_seg = 7'b1000000;
    end else begin
      pv   = disp_val;
      po   = disp_ovf;
      pidx = (e / DIV) % 4;
      e++;
      if (e == pend_edge) begin
        disp_val = pend_val;
        disp_ovf = pend_ovf;
      end
      if (v && !(acc <= e - 1 && e - 1 <= acc + N)) begin
        acc       = e;
        pend_edge = e + N + 1;
        pend_val  = d;
        pend_ovf  = (d > 9999);
      end
      exp_busy = (acc <= e && e <= acc + N) ? 1 : 0;
      exp_an   = (~(1 << pidx)) & 15;
      exp_seg  = seg_of(pv, po, pidx);
    end
    #1;
    chk("BUSY", int'(BUSY), exp_busy);
    chk("AN",   int'(AN),   exp_an);
    chk("SEG",  int'(SEG),  exp_seg);
    chk("DP",   int'(DP),   1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic convert(input int d, input int hold);
    step(1'b0, 1'b1, d);
    idle(hold);
  endtask

  initial begin
    // Reset held three cycles, then let the scan walk with the zero display
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    idle(20);

    convert(1234, 40);
    convert(9999, 40);
    convert(10000, 40);

    // Second strobe during conversion must be dropped
    step(1'b0, 1'b1, 305);
    idle(3);
    step(1'b0, 1'b1, 57);
    idle(40);

    // Reset in the sixth shift cycle aborts the conversion
    step(1'b0, 1'b1, 4321);
    idle(5);
    step(1'b1, 1'b0, 0);
    idle(20);

    convert(7, 40);
    convert(0, 40);
    convert(16383, 40);

    // Back-to-back strobes and random traffic
    for (int i = 0; i < 2500; i++) begin
      int sel, d;
      bit r, v;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       d = $urandom_range(10000, 16383);
        1:       d = $urandom_range(0, 99);
        default: d = $urandom_range(0, 9999);
      endcase
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 7) == 0);
      step(r, v, d);
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
